// File: rtl/mips_mc_control_if.sv
// mips_mc_control_if: control bus between the multicycle sequencer and its datapath
// master (sequencer) takes in opcode/funct/zero and drives the mux selects, write enables, alu_sel, illegal_op and halted
interface mips_mc_control_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic zero;
  logic pc_en;
  logic iord;
  logic mem_write;
  logic ir_write;
  logic reg_dst;
  logic mem_to_reg;
  logic reg_write;
  logic alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic [2:0] alu_sel;
  logic illegal_op;
  logic halted;
  modport master (
    input opcode, funct, zero,
    output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
    output alu_src_a, alu_src_b, pc_src, alu_sel, illegal_op, halted
  );
  modport slave (
    output opcode, funct, zero,
    input pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
    input alu_src_a, alu_src_b, pc_src, alu_sel, illegal_op, halted
  );
endinterface

// File: rtl/mips_mc_control.sv
// mips_mc_control: Moore sequencer of the multicycle MIPS core
// clk, rst_n (sync, active-low); bus: mips_mc_control_if.master carrying IR fields, zero flag and all datapath controls
module mips_mc_control #(
  parameter int STATE_W = 4,
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input logic clk,
  input logic rst_n,
  mips_mc_control_if.master bus
);
  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT
  } state_t;
  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04, OP_ADDI = 6'h08, OP_J = 6'h02;
  state_t state, nxt;
  logic pc_write, branch, ir_w, mem_w, reg_w, r_legal, legal;
  logic [2:0] r_sel;
  assign r_sel = bus.funct == 6'h20 ? 3'b010 :
                 bus.funct == 6'h22 ? 3'b110 :
                 bus.funct == 6'h24 ? 3'b000 :
                 bus.funct == 6'h25 ? 3'b001 :
                 bus.funct == 6'h2a ? 3'b111 : 3'b010;
  assign r_legal = bus.funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
  assign legal = (bus.opcode == OP_R && r_legal) || bus.opcode inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
  // enables are gated by rst_n so an aborted instruction never writes on the reset cycle
  assign bus.pc_en = rst_n & (pc_write | (branch & bus.zero));
  assign bus.ir_write = rst_n & ir_w;
  assign bus.mem_write = rst_n & mem_w;
  assign bus.reg_write = rst_n & reg_w;
  always_ff @(posedge clk) state <= !rst_n ? FETCH : nxt;
  always_comb begin
    nxt = FETCH;
    pc_write = 1'b0;
    branch = 1'b0;
    ir_w = 1'b0;
    mem_w = 1'b0;
    reg_w = 1'b0;
    bus.iord = 1'b0;
    bus.reg_dst = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = 2'b00;
    bus.pc_src = 2'b00;
    bus.alu_sel = 3'b010;
    bus.illegal_op = 1'b0;
    bus.halted = 1'b0;
    case (state)
      FETCH: begin
        ir_w = 1'b1;
        pc_write = 1'b1;
        bus.alu_src_b = 2'b01;
        nxt = DECODE;
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        bus.illegal_op = !legal;
        nxt = !legal ? (ILLEGAL_TRAP ? HALT : FETCH) :
              bus.opcode == OP_R ? EXEC :
              bus.opcode == OP_BEQ ? BRANCH :
              bus.opcode == OP_ADDI ? ADDIEX :
              bus.opcode == OP_J ? JUMP : MEMADR;
      end
      MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        nxt = bus.opcode == OP_LW ? MEMRD : MEMWR;
      end
      MEMRD: begin
        bus.iord = 1'b1;
        nxt = MEMWB;
      end
      MEMWB: begin
        reg_w = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        bus.iord = 1'b1;
        mem_w = 1'b1;
      end
      EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_sel = r_sel;
        nxt = ALUWB;
      end
      ALUWB: begin
        reg_w = 1'b1;
        bus.reg_dst = 1'b1;
      end
      BRANCH: begin
        bus.alu_src_a = 1'b1;
        bus.alu_sel = 3'b110;
        branch = 1'b1;
        bus.pc_src = 2'b01;
      end
      ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        nxt = ADDIWB;
      end
      ADDIWB: reg_w = 1'b1;
      JUMP: begin
        pc_write = 1'b1;
        bus.pc_src = 2'b10;
      end
      HALT: begin
        bus.halted = 1'b1;
        nxt = HALT;
      end
      default: nxt = FETCH;
    endcase
  end
endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: randomized per-instruction-step check of mips_mc_control against a cycle-table model
module tb_mips_mc_control;
  typedef struct packed {
    logic pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_sel;
    logic illegal_op, halted;
  } ov_t;
  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00, BEQ = 6'h04, ADDI = 6'h08, JMP = 6'h02;
  logic clk = 1'b0, rst_n = 1'b0, rst1_n = 1'b0;
  int n_cmp = 0, n_err = 0;
  ov_t o0, o1, e;
  mips_mc_control_if b0();
  mips_mc_control_if b1();
  mips_mc_control #(.STATE_W(4), .ILLEGAL_TRAP(1'b0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  mips_mc_control #(.STATE_W(4), .ILLEGAL_TRAP(1'b1)) u1 (.clk(clk), .rst_n(rst1_n), .bus(b1));
  always #5 clk = ~clk;
  assign o0 = {b0.pc_en, b0.iord, b0.mem_write, b0.ir_write, b0.reg_dst, b0.mem_to_reg, b0.reg_write,
               b0.alu_src_a, b0.alu_src_b, b0.pc_src, b0.alu_sel, b0.illegal_op, b0.halted};
  assign o1 = {b1.pc_en, b1.iord, b1.mem_write, b1.ir_write, b1.reg_dst, b1.mem_to_reg, b1.reg_write,
               b1.alu_src_a, b1.alu_src_b, b1.pc_src, b1.alu_sel, b1.illegal_op, b1.halted};
  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == RT) return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    return op inside {LW, SW, BEQ, ADDI, JMP};
  endfunction
  function automatic int len(input logic [5:0] op, input logic [5:0] fn);
    if (!legal(op, fn)) return 2;
    if (op == LW) return 5;
    if (op == BEQ || op == JMP) return 3;
    return 4;
  endfunction
  function automatic logic [2:0] rsel(input logic [5:0] fn);
    case (fn)
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h2a: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction
  function automatic ov_t model(input logic [5:0] op, input logic [5:0] fn, input logic z, input int s);
    ov_t v;
    v = '0;
    v.alu_sel = 3'b010;
    if (s == 0) begin
      v.ir_write = 1'b1;
      v.pc_en = 1'b1;
      v.alu_src_b = 2'b01;
    end else if (s == 1) begin
      v.alu_src_b = 2'b11;
      v.illegal_op = !legal(op, fn);
    end else if (op == LW || op == SW) begin
      if (s == 2) begin
        v.alu_src_a = 1'b1;
        v.alu_src_b = 2'b10;
      end else if (s == 3) begin
        v.iord = 1'b1;
        v.mem_write = (op == SW);
      end else begin
        v.reg_write = 1'b1;
        v.mem_to_reg = 1'b1;
      end
    end else if (op == RT) begin
      if (s == 2) begin
        v.alu_src_a = 1'b1;
        v.alu_sel = rsel(fn);
      end else begin
        v.reg_write = 1'b1;
        v.reg_dst = 1'b1;
      end
    end else if (op == ADDI) begin
      if (s == 2) begin
        v.alu_src_a = 1'b1;
        v.alu_src_b = 2'b10;
      end else v.reg_write = 1'b1;
    end else if (op == BEQ) begin
      v.alu_src_a = 1'b1;
      v.alu_sel = 3'b110;
      v.pc_src = 2'b01;
      v.pc_en = z;
    end else if (op == JMP) begin
      v.pc_en = 1'b1;
      v.pc_src = 2'b10;
    end
    return v;
  endfunction
  // entered just after a posedge with u0 in FETCH; leaves it the same way
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int abort, input int zf);
    int n;
    logic z;
    ov_t x;
    n = len(op, fn);
    b0.opcode = op;
    b0.funct = fn;
    for (int s = 0; s < n; s++) begin
      z = zf < 0 ? 1'($urandom_range(0, 1)) : 1'(zf);
      b0.zero = z;
      if (s == abort) rst_n = 1'b0;
      @(negedge clk);
      x = model(op, fn, z, s);
      if (s == abort) begin
        x.pc_en = 1'b0;
        x.ir_write = 1'b0;
        x.mem_write = 1'b0;
        x.reg_write = 1'b0;
      end
      chk($sformatf("op%h_fn%h_step%0d%s", op, fn, s, s == abort ? "_rst" : ""), o0, x);
      @(posedge clk);
      #1;
      if (s == abort) begin
        rst_n = 1'b1;
        break;
      end
    end
  endtask
  initial begin
    logic [5:0] op, fn;
    logic [5:0] ops [7];
    logic [5:0] fns [5];
    ops = '{LW, SW, RT, RT, BEQ, ADDI, JMP};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
    b0.opcode = '0;
    b0.funct = '0;
    b0.zero = 1'b0;
    b1.opcode = '0;
    b1.funct = '0;
    b1.zero = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_enables", 17'({o0.pc_en, o0.ir_write, o0.mem_write, o0.reg_write}), 17'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(LW, 6'h00, -1, -1);
    run(RT, 6'h2a, -1, -1);
    run(BEQ, 6'h00, -1, 1);
    run(BEQ, 6'h00, -1, 0);
    run(6'h3f, 6'h00, -1, -1);
    run(RT, 6'h3f, -1, -1);
    run(SW, 6'h00, 3, -1);
    run(ADDI, 6'h00, -1, -1);
    run(JMP, 6'h00, -1, -1);
    for (int i = 0; i < 300; i++) begin
      op = $urandom_range(0, 7) == 7 ? 6'($urandom) : ops[$urandom_range(0, 6)];
      fn = $urandom_range(0, 4) == 0 ? 6'($urandom) : fns[$urandom_range(0, 4)];
      run(op, fn, $urandom_range(0, 9) == 0 ? int'($urandom_range(0, 4)) : -1, -1);
    end
    b1.opcode = 6'h3f;
    rst1_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      chk($sformatf("trap_step%0d", s), o1, model(6'h3f, 6'h00, 1'b0, s));
      @(posedge clk);
      #1;
    end
    e = '0;
    e.alu_sel = 3'b010;
    e.halted = 1'b1;
    for (int c = 0; c < 12; c++) begin
      b1.opcode = 6'($urandom);
      b1.zero = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk($sformatf("halt_cyc%0d", c), o1, e);
      @(posedge clk);
      #1;
    end
    rst1_n = 1'b0;
    @(posedge clk);
    #1;
    rst1_n = 1'b1;
    @(negedge clk);
    chk("halt_recover", o1, model(6'h3f, 6'h00, 1'b0, 0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
